// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdio_pkg
// Description : Shared definitions for the Clause 22 MDIO receiver: FSM state
//               encoding, frame field codes, bit positions within a frame and
//               a helper that sizes the preamble counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_DATA  = 3'd6,
        S_SKIP  = 3'd7
    } mdio_state_e;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    // Index of the last bit of each field; bit 0 is the first ST bit.
    localparam logic [4:0] OP_LAST    = 5'd3;
    localparam logic [4:0] PHYAD_LSB  = 5'd8;
    localparam logic [4:0] REGAD_LSB  = 5'd13;
    localparam logic [4:0] TA_LAST    = 5'd15;
    localparam logic [4:0] FRAME_LAST = 5'd31;

    // Counter must be able to hold the value PRE_MIN itself.
    function automatic int unsigned pre_cnt_w(input int unsigned pre_min);
        return $clog2(pre_min + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_preamble_det.sv
`default_nettype none
// ============================================================================
// Module      : mdio_preamble_det
// Description : Saturating counter of consecutive preamble ones. pre_ok_o is
//               high once at least PRE_MIN ones have been counted.
// Ports       : clk_i    - management clock (rising edge)
//               rst_ni   - asynchronous active-low reset
//               inc_i    - a valid '1' was sampled this edge
//               clr_i    - clear the count this edge (has priority)
//               pre_ok_o - count >= PRE_MIN
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_preamble_det
    import mdio_pkg::*;
#(
    parameter int unsigned PRE_MIN = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic pre_ok_o
);

    localparam int unsigned    CW    = pre_cnt_w(PRE_MIN);
    localparam logic [CW-1:0]  C_MAX = CW'(PRE_MIN);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != C_MAX)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign pre_ok_o = (cnt_q >= C_MAX);

endmodule
`default_nettype wire

// File: rtl/mdio_receptor_param.sv
`default_nettype none
// ============================================================================
// Module      : mdio_receptor_param
// Description : PHY-side Clause 22 MDIO receiver. Deserialises STA frames,
//               filters on PHY address, serves reads via RD_STB/RD_DATA and
//               presents writes as a single WR_STB pulse.
// Ports       : MDC, RESET (async, active-low)
//               MDIO_OUT/MDIO_OE    - serial data / drive enable from STA
//               MDIO_IN/MDIO_IN_OE  - serial read data / enable to STA
//               ADDR, WR_DATA, WR_STB, RD_STB, RD_DATA - register bank side
//               MDIO_DONE, FRAME_ERR - frame completion / protocol error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_receptor_param
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter bit          BCAST_EN = 1'b1,
    parameter int unsigned PRE_MIN  = 32
) (
    input  logic        MDC,
    input  logic        RESET,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    input  logic [15:0] RD_DATA,
    output logic        MDIO_DONE,
    output logic        FRAME_ERR
);

    mdio_state_e state_q;
    logic [4:0]  bit_q;       // index of the frame bit sampled at this edge
    logic [15:0] sh_q;        // header/write-data shift in, read-data shift out
    logic        is_rd_q;
    logic [4:0]  regad_q;
    logic [4:0]  addr_q;
    logic [15:0] wr_data_q;
    logic        in_q, in_oe_q;
    logic        rd_stb_q, wr_stb_q, done_q, err_q;

    logic        w_pre_inc, w_pre_ok, w_phy_ok;
    logic [1:0]  w_pair;
    logic [4:0]  w_field5;

    // The counter only advances on ones seen in IDLE; anything else (a zero,
    // an undriven bit, or being inside a frame) clears it, so each frame
    // needs a fresh preamble.
    assign w_pre_inc = (state_q == S_IDLE) && MDIO_OE && MDIO_OUT;

    mdio_preamble_det #(.PRE_MIN(PRE_MIN)) u_pre (
        .clk_i    (MDC),
        .rst_ni   (RESET),
        .inc_i    (w_pre_inc),
        .clr_i    (!w_pre_inc),
        .pre_ok_o (w_pre_ok)
    );

    assign w_pair   = {sh_q[0], MDIO_OUT};
    assign w_field5 = {sh_q[3:0], MDIO_OUT};
    // Broadcast address is honoured for writes only.
    assign w_phy_ok = (w_field5 == PHY_ADDR) ||
                      (BCAST_EN && (w_field5 == 5'd0) && !is_rd_q);

    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            bit_q     <= '0;
            sh_q      <= '0;
            is_rd_q   <= 1'b0;
            regad_q   <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            in_q      <= 1'b0;
            in_oe_q   <= 1'b0;
            rd_stb_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    bit_q <= '0;
                    if (MDIO_OE && !MDIO_OUT && w_pre_ok) begin
                        state_q <= S_ST;
                        bit_q   <= 5'd1;
                        sh_q    <= {sh_q[14:0], MDIO_OUT};
                    end
                end
                S_ST: begin
                    if (!MDIO_OE || (w_pair != ST_CODE)) begin
                        err_q <= 1'b1; state_q <= S_IDLE; bit_q <= '0;
                    end else begin
                        state_q <= S_OP;
                        bit_q   <= bit_q + 5'd1;
                        sh_q    <= {sh_q[14:0], MDIO_OUT};
                    end
                end
                S_OP: begin
                    if (!MDIO_OE || ((bit_q == OP_LAST) &&
                        (w_pair != OP_READ) && (w_pair != OP_WRITE))) begin
                        err_q <= 1'b1; state_q <= S_IDLE; bit_q <= '0;
                    end else begin
                        bit_q <= bit_q + 5'd1;
                        sh_q  <= {sh_q[14:0], MDIO_OUT};
                        if (bit_q == OP_LAST) begin
                            is_rd_q <= (w_pair == OP_READ);
                            state_q <= S_PHYAD;
                        end
                    end
                end
                S_PHYAD: begin
                    if (!MDIO_OE) begin
                        err_q <= 1'b1; state_q <= S_IDLE; bit_q <= '0;
                    end else begin
                        bit_q <= bit_q + 5'd1;
                        sh_q  <= {sh_q[14:0], MDIO_OUT};
                        if (bit_q == PHYAD_LSB) begin
                            state_q <= w_phy_ok ? S_REGAD : S_SKIP;
                        end
                    end
                end
                S_REGAD: begin
                    if (!MDIO_OE) begin
                        err_q <= 1'b1; state_q <= S_IDLE; bit_q <= '0;
                    end else begin
                        bit_q <= bit_q + 5'd1;
                        sh_q  <= {sh_q[14:0], MDIO_OUT};
                        if (bit_q == REGAD_LSB) begin
                            regad_q <= w_field5;
                            state_q <= S_TA;
                            if (is_rd_q) begin
                                addr_q   <= w_field5;
                                rd_stb_q <= 1'b1;
                            end
                        end
                    end
                end
                S_TA: begin
                    if (is_rd_q) begin
                        // Line is ours from the second TA bit onward.
                        bit_q <= bit_q + 5'd1;
                        if (bit_q == TA_LAST) begin
                            in_q    <= RD_DATA[15];
                            sh_q    <= {RD_DATA[14:0], 1'b0};
                            state_q <= S_DATA;
                        end else begin
                            in_oe_q <= 1'b1;
                            in_q    <= 1'b0;
                        end
                    end else if (!MDIO_OE || (MDIO_OUT == (bit_q == TA_LAST))) begin
                        // Write TA must be 1 then 0.
                        err_q <= 1'b1; state_q <= S_IDLE; bit_q <= '0;
                    end else begin
                        bit_q <= bit_q + 5'd1;
                        sh_q  <= {sh_q[14:0], MDIO_OUT};
                        if (bit_q == TA_LAST) begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (is_rd_q) begin
                        if (bit_q == FRAME_LAST) begin
                            in_oe_q <= 1'b0;
                            in_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            bit_q   <= '0;
                        end else begin
                            in_q  <= sh_q[15];
                            sh_q  <= {sh_q[14:0], 1'b0};
                            bit_q <= bit_q + 5'd1;
                        end
                    end else if (!MDIO_OE) begin
                        err_q <= 1'b1; state_q <= S_IDLE; bit_q <= '0;
                    end else if (bit_q == FRAME_LAST) begin
                        wr_data_q <= {sh_q[14:0], MDIO_OUT};
                        addr_q    <= regad_q;
                        wr_stb_q  <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                        bit_q     <= '0;
                    end else begin
                        sh_q  <= {sh_q[14:0], MDIO_OUT};
                        bit_q <= bit_q + 5'd1;
                    end
                end
                S_SKIP: begin
                    if (bit_q == FRAME_LAST) begin
                        state_q <= S_IDLE;
                        bit_q   <= '0;
                    end else begin
                        bit_q <= bit_q + 5'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    bit_q   <= '0;
                end
            endcase
        end
    end

    assign MDIO_IN    = in_q;
    assign MDIO_IN_OE = in_oe_q;
    assign ADDR       = addr_q;
    assign WR_DATA    = wr_data_q;
    assign WR_STB     = wr_stb_q;
    assign RD_STB     = rd_stb_q;
    assign MDIO_DONE  = done_q;
    assign FRAME_ERR  = err_q;

endmodule
`default_nettype wire

// File: doc/mdio_receptor_param.md
Name: mdio_receptor_param

Overview:
- PHY-side MDIO management receiver (Clause 22), the parametrised successor of the fixed MDIO receptor.
- Deserialises STA frames on MDIO_OUT/MDIO_OE and filters them by a configurable PHY address.
- Enforces a configurable minimum preamble and flags malformed frames.
- Serves reads through an RD_STB/RD_DATA request handshake; presents writes as a single WR_STB pulse to the register bank.

Parameters:
PHY_ADDR, 5'd1, PHY address this instance answers to.
BCAST_EN, 1, 1 = PHYAD 0 also accepted for writes (broadcast); reads to PHYAD 0 ignored.
PRE_MIN, 32, minimum consecutive sampled 1s required before ST; legal range 1..64.

Ports:
MDC  input  1  management clock; all state updates on rising edge.
RESET  input  1  asynchronous, active-low reset.
MDIO_OUT  input  1  serial data from STA.
MDIO_OE  input  1  STA drive enable; a bit is valid only when 1.
MDIO_IN  output  1  serial read data to STA.
MDIO_IN_OE  output  1  receiver drive enable for MDIO_IN.
ADDR  output  5  register address of current transaction.
WR_DATA  output  16  write data.
WR_STB  output  1  one-cycle write strobe.
RD_STB  output  1  one-cycle read request.
RD_DATA  input  16  read data from register bank.
MDIO_DONE  output  1  one-cycle pulse at end of an accepted frame.
FRAME_ERR  output  1  one-cycle pulse on protocol error.

Behaviour:
Reset and bit numbering
- Reset (RESET=0, asynchronous) forces: all outputs 0, state IDLE, preamble count 0. Reset mid-read drops MDIO_IN_OE immediately.
- Frame bit k is sampled at rising edge k, where edge 0 is the ST first bit.
- Bit map: ST 0-1 (01), OP 2-3 (10 read, 01 write), PHYAD 4-8, REGAD 9-13, TA 14-15, DATA 16-31. All fields MSB first.

States: IDLE, ST, OP, PHYAD, REGAD, TA, DATA, SKIP.

Preamble (IDLE)
- Saturating counter of consecutive samples with MDIO_OE=1 and MDIO_OUT=1.
- MDIO_OE=1 and MDIO_OUT=0 with count >= PRE_MIN: that sample is ST bit0; go to ST.
- MDIO_OE=1 and MDIO_OUT=0 with count < PRE_MIN: count clears; no error.
- MDIO_OE=0: count clears.

Header errors (ST, OP, PHYAD, REGAD)
- Any sample with MDIO_OE=0, ST != 01, or OP in {00,11}: FRAME_ERR pulses after that edge; go to IDLE, count 0.

Address filter
- PHYAD == PHY_ADDR: accept.
- PHYAD == 0 with BCAST_EN=1 and OP=write: accept.
- Otherwise: SKIP, counting through edge 31 ignoring the line, no outputs, then IDLE.

Read (accepted)
- ADDR valid from edge 13.
- RD_STB high for the cycle between edges 13 and 14.
- RD_DATA must be stable at edge 15 and is latched there.
- Edge 14: MDIO_IN_OE=1, MDIO_IN=0 (TA second bit).
- Edges 15..30: MDIO_IN = RD_DATA[15..0].
- Edge 31: MDIO_IN_OE=0, MDIO_IN=0, MDIO_DONE pulse.
- MDIO_OE and MDIO_OUT are ignored from edge 14 on.

Write (accepted)
- TA must sample 1 then 0 with MDIO_OE=1. Otherwise FRAME_ERR pulses and the block returns to IDLE.
- Data shifts in on edges 16..31.
- After edge 31: WR_DATA and ADDR updated, WR_STB and MDIO_DONE pulse together for one cycle.
- WR_DATA and ADDR hold until the next accepted frame.
- MDIO_OE=0 during DATA: FRAME_ERR pulse, IDLE, no WR_STB.

General rules
- After every frame, error, or SKIP, preamble count is 0; back-to-back frames each need PRE_MIN ones.
- RD_STB, WR_STB, MDIO_DONE and FRAME_ERR are never high simultaneously except WR_STB with MDIO_DONE.
- MDIO_IN_OE is never 1 outside edges 14..30 of an accepted read.

Decomposition:
- Package mdio_pkg holds:
  - state encoding;
  - ST code 2'b01, OP_READ 2'b10, OP_WRITE 2'b01;
  - field bit positions (PHYAD_LSB=8, REGAD_LSB=13, TA_LAST=15, FRAME_LAST=31);
  - preamble counter width, computed from PRE_MIN.
- One sub-module, mdio_preamble_det: saturating ones-counter with pre_ok output and clear input.
- Main FSM, 5-bit bit counter, 16-bit shift register and output registers stay in mdio_receptor_param.

Test Plan:
1. PHY_ADDR=1: 32 ones, read frame 01 10 00001 00011, RD_DATA=16'h8FF1 -> RD_STB one cycle with ADDR=3; MDIO_IN_OE high edges 14..30; MDIO_IN = 0 then 1000111111110001; MDIO_DONE at edge 31.
2. 32 ones, write 01 01 00001 00100 10 16'hA5C3 -> WR_STB and MDIO_DONE one cycle after edge 31, ADDR=4, WR_DATA=16'hA5C3; FRAME_ERR stays 0.
3. Write to PHYAD 5 -> no strobes, no errors; an immediately following valid read with only 31 ones is ignored; the same read with 32 ones succeeds.
4. BCAST_EN=1: write to PHYAD 0 -> WR_STB asserted. Read to PHYAD 0 -> no RD_STB, MDIO_IN_OE stays 0.
5. Errors: ST=00 -> FRAME_ERR at edge 1. OP=11 -> FRAME_ERR at edge 3. Write TA=11 -> FRAME_ERR at edge 15, no WR_STB.
6. RESET low during read data at edge 20 -> MDIO_IN_OE and all outputs 0 immediately. After release, a full valid read completes normally.
